// File: rtl/tff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tff_bank_arbiter
//   A bank of NBITS toggle flip-flops shared by NREQ requesters. A round-robin
//   arbiter grants at most one request per cycle. The winner's req_idx bit of
//   the bank toggles one cycle after the request is sampled.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      per-requester toggle request
//   req_idx  per-requester bit index, slice [i*IDXW +: IDXW]
//   clr      synchronous clear of the whole bank (requests stay pending)
//   gnt      registered one-hot grant pulse
//   gnt_id   index of the requester granted (valid when |gnt)
//   q        toggle-flop bank state
//   err_idx  registered pulse: the granted index was out of range
// -----------------------------------------------------------------------------
module tff_bank_arbiter #(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned NBITS = 8,
  localparam int unsigned IDXW  = $clog2(NBITS),
  localparam int unsigned GIDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic [GIDW-1:0]      gnt_id,
  output logic [NBITS-1:0]     q,
  output logic                 err_idx
);

  localparam int unsigned SUMW = GIDW + 1;

  logic [NBITS-1:0] r_q;
  logic [NREQ-1:0]  r_gnt;
  logic [GIDW-1:0]  r_gnt_id;
  logic             r_err;
  logic [GIDW-1:0]  r_ptr;

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_rot;
  logic             w_any;
  logic [GIDW-1:0]  w_off;
  logic [SUMW-1:0]  w_sum;
  logic [GIDW-1:0]  w_win;
  logic [IDXW-1:0]  w_sel_idx;
  logic             w_idx_ok;
  logic [NBITS-1:0] w_mask;

  // Round-robin pick: rotate the eligible set so ptr sits at bit 0, take the
  // lowest set bit, then rotate the offset back into a requester index.
  always_comb begin
    w_elig = req & ~r_gnt;
    w_any  = |w_elig;
    w_rot  = NREQ'({w_elig, w_elig} >> r_ptr);
    w_off  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = GIDW'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= SUMW'(NREQ)) w_win = GIDW'(w_sum - SUMW'(NREQ));
    else                      w_win = GIDW'(w_sum);
  end

  // Winner's bit index and the one-hot toggle mask it produces.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_win == GIDW'(i)) w_sel_idx = req_idx[i*IDXW +: IDXW];
    end
    w_idx_ok = (32'(w_sel_idx) < NBITS);
    w_mask   = w_idx_ok ? (NBITS'(1) << w_sel_idx) : '0;
  end

  // Grant, pointer and bank update; clr wins over arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q      <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_err    <= 1'b0;
      r_ptr    <= '0;
    end else if (clr) begin
      r_q   <= '0;
      r_gnt <= '0;
      r_err <= 1'b0;
    end else if (w_any) begin
      r_gnt    <= NREQ'(1) << w_win;
      r_gnt_id <= w_win;
      r_ptr    <= (w_win == GIDW'(NREQ - 1)) ? '0 : w_win + GIDW'(1);
      r_q      <= r_q ^ w_mask;
      r_err    <= ~w_idx_ok;
    end else begin
      r_gnt <= '0;
      r_err <= 1'b0;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign q       = r_q;
  assign err_idx = r_err;

  // Embedded checks.
  GNT_ONEHOT: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("GNT_ONEHOT violated");

  GNT_HAS_REQ: assert property (@(posedge clk) disable iff (rst)
    ((gnt & ~$past(req)) == '0))
    else $error("GNT_HAS_REQ violated");

  SINGLE_TOGGLE: assert property (@(posedge clk) disable iff (rst)
    !$past(clr) |-> ($countones(q ^ $past(q)) <= 1))
    else $error("SINGLE_TOGGLE violated");

  CLR_ZERO: assert property (@(posedge clk) disable iff (rst) clr |=> (q == '0))
    else $error("CLR_ZERO violated");

  RST_ZERO: assert property (@(posedge clk) disable iff (rst)
    rst |=> (q == '0 && gnt == '0))
    else $error("RST_ZERO violated");

  // Per-requester wait counter: cycles a request has been held without a grant.
  for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_starve
    logic [7:0] r_wait;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_wait <= '0;
      else if (!req[gi] || gnt[gi] || clr)    r_wait <= '0;
      else if (r_wait != 8'hFF)               r_wait <= r_wait + 8'd1;
    end
    NO_STARVE: assert property (@(posedge clk) disable iff (rst)
      32'(r_wait) <= 2 * NREQ)
      else $error("NO_STARVE violated");
  end

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tff_bank_arbiter
//   Directed scenarios plus constrained-random traffic on an 8-bit bank, and a
//   6-bit bank instance for out-of-range index handling. Expected values come
//   from a behavioural model of the arbitration and toggle rules.
// -----------------------------------------------------------------------------
module tb_tff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDXW  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_idx;
  logic        clr;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  q;
  logic        err_idx;

  logic [3:0]  req6;
  logic [11:0] idx6;
  logic        clr6;
  logic [3:0]  gnt6;
  logic [1:0]  gid6;
  logic [5:0]  q6;
  logic        err6;

  always #5 clk = ~clk;

  tff_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_idx(req_idx), .clr(clr),
    .gnt(gnt), .gnt_id(gnt_id), .q(q), .err_idx(err_idx)
  );

  tff_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .req_idx(idx6), .clr(clr6),
    .gnt(gnt6), .gnt_id(gid6), .q(q6), .err_idx(err6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model of the 8-bit instance.
  logic [7:0] m_q;
  logic [3:0] m_gnt;
  logic [1:0] m_gid;
  logic       m_err;
  int         m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_gnt = '0; m_gid = '0; m_err = 1'b0; m_ptr = 0;
  endtask

  // One clock edge of the model, from the inputs currently applied.
  task automatic model_edge();
    logic [3:0] e;
    int w, c, ix;
    if (clr) begin
      m_q = '0; m_gnt = '0; m_err = 1'b0;
    end else begin
      e = req & ~m_gnt;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (w < 0 && e[c]) w = c;
      end
      if (w < 0) begin
        m_gnt = '0; m_err = 1'b0;
      end else begin
        ix = int'(req_idx[w*IDXW +: IDXW]);
        m_gnt = '0;
        m_gnt[w] = 1'b1;
        m_gid = 2'(w);
        m_ptr = (w + 1) % NREQ;
        if (ix < NBITS) begin
          m_q[ix] = ~m_q[ix];
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q"},      32'(q),       32'(m_q));
    chk({tag, "_gnt"},    32'(gnt),     32'(m_gnt));
    chk({tag, "_gnt_id"}, 32'(gnt_id),  32'(m_gid));
    chk({tag, "_err"},    32'(err_idx), 32'(m_err));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t2_q5;
    logic [3:0] t2_g2;
    logic [3:0] seen;
    t2_q5 = 4'b0011;
    t2_g2 = 4'b0101;

    rst = 1'b1; clr = 1'b0;
    req = 4'b1111;
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req6 = '0; idx6 = '0; clr6 = 1'b0;
    model_reset();

    // Reset with all requests asserted.
    repeat (2) @(posedge clk);
    #1;
    check_all("t1_rst");
    chk("t1_rst_q6",   32'(q6),   32'd0);
    chk("t1_rst_gnt6", 32'(gnt6), 32'd0);
    rst = 1'b0;

    // First grant to requester 0, then round-robin 0,1,2,3 with all held.
    for (int k = 0; k < 8; k++) begin
      step("t3");
      chk("t3_gid_seq", 32'(gnt_id), 32'(k % 4));
      if (k == 0) chk("t1_first_gnt", 32'(gnt), 32'h1);
      if (k == 3) chk("t3_q_round1", 32'(q[3:0]), 32'hF);
      if (k == 7) chk("t3_q_round2", 32'(q[3:0]), 32'h0);
    end

    // Single requester held four cycles: grant every other cycle.
    req = '0; clr = 1'b1;
    step("t2_clr");
    clr = 1'b0;
    req = 4'b0100;
    req_idx[2*IDXW +: IDXW] = 3'd5;
    for (int k = 0; k < 4; k++) begin
      step("t2");
      chk("t2_q5",   32'(q[5]),   32'(t2_q5[k]));
      chk("t2_gnt2", 32'(gnt[2]), 32'(t2_g2[k]));
    end

    // Two requesters on the same bit: serialized, bit returns to start.
    req = 4'b0011;
    req_idx[0 +: IDXW]    = 3'd3;
    req_idx[IDXW +: IDXW] = 3'd3;
    seen = '0;
    for (int k = 0; k < 2; k++) begin
      step("t4");
      seen = seen | gnt;
    end
    chk("t4_both_granted", 32'(seen), 32'h3);
    chk("t4_q3_restored",  32'(q[3]), 32'd0);
    req = '0;
    step("t4_idle");

    // Build q = A5, then clear with a pending request.
    clr = 1'b1;
    step("t5_pre_clr");
    clr = 1'b0;
    req = 4'b1111;
    req_idx = {3'd7, 3'd5, 3'd2, 3'd0};
    for (int k = 0; k < 4; k++) step("t5_fill");
    chk("t5_q_a5", 32'(q), 32'hA5);
    req = 4'b0010;
    req_idx[IDXW +: IDXW] = 3'd0;
    clr = 1'b1;
    step("t5_clr");
    chk("t5_clr_q",   32'(q),   32'h0);
    chk("t5_clr_gnt", 32'(gnt), 32'h0);
    clr = 1'b0;
    step("t5_after");
    chk("t5_after_gnt", 32'(gnt), 32'h2);
    chk("t5_after_q",   32'(q),   32'h01);
    req = '0;

    // Out-of-range index on the 6-bit bank.
    req6 = 4'b1000;
    idx6[3*IDXW +: IDXW] = 3'd7;
    step("t6a");
    chk("t6_gnt6", 32'(gnt6), 32'h8);
    chk("t6_gid6", 32'(gid6), 32'd3);
    chk("t6_err6", 32'(err6), 32'd1);
    chk("t6_q6",   32'(q6),   32'd0);
    req6 = '0;
    step("t6b");
    chk("t6_idle_err6", 32'(err6), 32'd0);
    chk("t6_idle_gnt6", 32'(gnt6), 32'd0);
    req6 = 4'b1111;
    idx6 = {3'd2, 3'd2, 3'd6, 3'd1};
    step("t6c");
    chk("t6_ptr_wrap_gid6", 32'(gid6), 32'd0);
    chk("t6_ptr_wrap_q6",   32'(q6),   32'h02);
    chk("t6_ptr_wrap_err6", 32'(err6), 32'd0);
    step("t6d");
    chk("t6_idx6_gid6", 32'(gid6), 32'd1);
    chk("t6_idx6_err6", 32'(err6), 32'd1);
    chk("t6_idx6_q6",   32'(q6),   32'h02);
    req6 = '0;

    // Random traffic obeying the hold-until-grant contract.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || m_gnt[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          req_idx[i*IDXW +: IDXW] = 3'($urandom_range(0, 7));
        end
      end
      clr = ($urandom_range(0, 15) == 0);
      step("rnd");
    end
    req = '0; clr = 1'b0;
    step("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
